// File: rtl/cp_insert64_pkg.sv
// Shared definitions for the cyclic-prefix inserter: symbol length, index width,
// FSM state encoding and default sample widths.
package cp_insert64_pkg;

  localparam int unsigned N          = 64;
  localparam int unsigned IDX_W      = $clog2(N);
  localparam int unsigned DEF_IN_W   = 24;
  localparam int unsigned DEF_OUT_W  = 16;
  localparam int unsigned DEF_SHIFT  = 8;
  localparam int unsigned DEF_CP_LEN = 16;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_CP    = 2'd1,
    ST_BODY  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/cp_round_sat.sv
// Round-half-up arithmetic right shift of one signed component, then reduce
// to OUT_W bits.
// Build option: CP_INSERT64_SAT_EN defined  -> out-of-range results clamp;
//               CP_INSERT64_SAT_EN undefined -> low OUT_W bits kept (wrap).
// Ports:
//   din    - IN_W-bit signed input component
//   dout_c - OUT_W-bit signed result (combinational)
module cp_round_sat #(
  parameter int unsigned IN_W  = 24,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned SHIFT = 8
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout_c
);

  localparam int unsigned EW = IN_W + 1;
  localparam logic signed [EW-1:0] RND = EW'(2 ** (SHIFT - 1));

  if (SHIFT < 1 || SHIFT > IN_W - 1) begin : g_bad_shift
    $error("cp_round_sat: SHIFT must be in 1..IN_W-1");
  end

  logic signed [EW-1:0] ext_c;
  logic signed [EW-1:0] sum_c;
  logic signed [EW-1:0] shr_c;

`ifdef CP_INSERT64_SAT_EN
  localparam logic signed [EW-1:0] MAXV = {{(EW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [EW-1:0] MINV = ~MAXV;
`endif

  // One guard bit keeps the rounding add from overflowing.
  always_comb begin
    ext_c = {din[IN_W-1], din};
    sum_c = ext_c + RND;
    shr_c = sum_c >>> SHIFT;
`ifdef CP_INSERT64_SAT_EN
    if (shr_c > MAXV) begin
      dout_c = OUT_W'(MAXV);
    end else if (shr_c < MINV) begin
      dout_c = OUT_W'(MINV);
    end else begin
      dout_c = OUT_W'(shr_c);
    end
`else
    dout_c = OUT_W'(shr_c);
`endif
  end

endmodule

// File: rtl/cp_insert64.sv
// Cyclic-prefix inserter: buffers one 64-sample IFFT symbol, then streams the
// last CP_LEN samples followed by all 64 samples, each rounded/scaled to OUT_W.
// Build option: CP_INSERT64_SAT_EN selects saturation instead of wrap on scaling.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   in_re/in_im         - IN_W signed input sample, with in_valid/in_ready
//   out_re/out_im       - OUT_W signed output sample, with out_valid/out_ready
//   out_sop/out_eop     - first prefix beat / last body beat of a symbol
module cp_insert64
  import cp_insert64_pkg::*;
#(
  parameter int unsigned CP_LEN = DEF_CP_LEN,
  parameter int unsigned IN_W   = DEF_IN_W,
  parameter int unsigned OUT_W  = DEF_OUT_W,
  parameter int unsigned SHIFT  = DEF_SHIFT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_re,
  input  logic [IN_W-1:0]  in_im,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_re,
  output logic [OUT_W-1:0] out_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sop,
  output logic             out_eop
);

  if (CP_LEN == 0 || CP_LEN > 32) begin : g_bad_cp_len
    $error("cp_insert64: CP_LEN must be in 1..32");
  end

  localparam logic [IDX_W-1:0] CP_START = IDX_W'(N - CP_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               out_sop_q, out_sop_d;
  logic               out_eop_q, out_eop_d;
  logic [OUT_W-1:0]   out_re_q, out_re_d;
  logic [OUT_W-1:0]   out_im_q, out_im_d;

  logic [IN_W-1:0]    mem_re_q [N];
  logic [IN_W-1:0]    mem_im_q [N];

  logic               in_fire_c;
  logic               out_fire_c;
  logic               load_ok_c;
  logic [IN_W-1:0]    rd_re_c;
  logic [IN_W-1:0]    rd_im_c;
  logic [OUT_W-1:0]   scl_re_c;
  logic [OUT_W-1:0]   scl_im_c;

  assign in_fire_c  = in_valid && in_ready_q && (state_q == ST_FILL);
  assign out_fire_c = out_valid_q && out_ready;
  // Output register may take a new beat when empty or being drained this edge.
  assign load_ok_c  = !out_valid_q || out_ready;

  // Asynchronous-read symbol buffer.
  assign rd_re_c = mem_re_q[rd_idx_q];
  assign rd_im_c = mem_im_q[rd_idx_q];

  cp_round_sat #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_scale_re (
    .din    (rd_re_c),
    .dout_c (scl_re_c)
  );

  cp_round_sat #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_scale_im (
    .din    (rd_im_c),
    .dout_c (scl_im_c)
  );

  // Buffer storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (in_fire_c) begin
      mem_re_q[wr_cnt_q] <= in_re;
      mem_im_q[wr_cnt_q] <= in_im;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_idx_d    = rd_idx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;

    if (out_fire_c) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_FILL: begin
        in_ready_d = 1'b1;
        if (in_fire_c) begin
          wr_cnt_d = wr_cnt_q + IDX_W'(1);
          if (wr_cnt_q == LAST_IDX) begin
            state_d    = ST_CP;
            wr_cnt_d   = '0;
            rd_idx_d   = CP_START;
            in_ready_d = 1'b0;
          end
        end
      end

      ST_CP: begin
        if (load_ok_c) begin
          out_valid_d = 1'b1;
          out_re_d    = scl_re_c;
          out_im_d    = scl_im_c;
          out_sop_d   = (rd_idx_q == CP_START);
          out_eop_d   = 1'b0;
          rd_idx_d    = rd_idx_q + IDX_W'(1);
          if (rd_idx_q == LAST_IDX) begin
            state_d  = ST_BODY;
            rd_idx_d = '0;
          end
        end
      end

      ST_BODY: begin
        if (load_ok_c) begin
          out_valid_d = 1'b1;
          out_re_d    = scl_re_c;
          out_im_d    = scl_im_c;
          out_sop_d   = 1'b0;
          out_eop_d   = (rd_idx_q == LAST_IDX);
          rd_idx_d    = rd_idx_q + IDX_W'(1);
          if (rd_idx_q == LAST_IDX) begin
            state_d  = ST_DRAIN;
            rd_idx_d = '0;
          end
        end
      end

      ST_DRAIN: begin
        // Register still holds the eop beat; reopen input once it leaves.
        if (out_fire_c && out_eop_q) begin
          state_d    = ST_FILL;
          in_ready_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      wr_cnt_q    <= '0;
      rd_idx_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_idx_q    <= rd_idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;

endmodule
